spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 119 +++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-3 master that sends and receives one byte per start, MSB first.
// Ports:
//   clk      system clock, rising edge
//   rstn     asynchronous active-low reset
//   start    transfer request, sampled only in IDLE
//   tx_data  byte to send, captured when start is accepted
//   rx_data  last received byte, updated with done
//   busy     high for the duration of a transfer
//   done     one-cycle pulse when a transfer completes
//   cs       active-low slave select
//   sck      serial clock, idle high
//   mosi     serial data out, changes on sck fall
//   miso     serial data in, sampled on sck rise
module spi_master #(
    parameter int HALF = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SCK_LO, SCK_HI, HOLD} state_t;
    state_t state, state_n;
    logic [7:0] ph, ph_n;
    logic [2:0] bc, bc_n;
    logic [7:0] tx_sr, tx_n, rx_sr, rx_n, rx_data_n;
    logic busy_n, done_n, cs_n, sck_n, mosi_n, tick;
    assign tick = ph == 8'(HALF - 1);
    always_comb begin
        state_n   = state;
        ph_n      = tick ? 8'd0 : ph + 8'd1;
        bc_n      = bc;
        tx_n      = tx_sr;
        rx_n      = rx_sr;
        rx_data_n = rx_data;
        busy_n    = busy;
        done_n    = 1'b0;
        cs_n      = cs;
        sck_n     = sck;
        mosi_n    = mosi;
        case (state)
            IDLE: begin
                ph_n = 8'd0;
                if (start) begin
                    state_n = SETUP;
                    tx_n    = tx_data;
                    bc_n    = 3'd0;
                    cs_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            SETUP: if (tick) begin
                state_n = SCK_LO;
                sck_n   = 1'b0;
                mosi_n  = tx_sr[7];
                tx_n    = {tx_sr[6:0], 1'b0};
            end
            SCK_LO: if (tick) begin
                state_n = SCK_HI;
                sck_n   = 1'b1;
                rx_n    = {rx_sr[6:0], miso};
            end
            SCK_HI: if (tick) begin
                // after the eighth high phase sck stays high through HOLD
                if (bc == 3'd7) begin
                    state_n = HOLD;
                end else begin
                    state_n = SCK_LO;
                    sck_n   = 1'b0;
                    mosi_n  = tx_sr[7];
                    tx_n    = {tx_sr[6:0], 1'b0};
                    bc_n    = bc + 3'd1;
                end
            end
            HOLD: if (tick) begin
                state_n   = IDLE;
                cs_n      = 1'b1;
                busy_n    = 1'b0;
                done_n    = 1'b1;
                rx_data_n = rx_sr;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ph      <= 8'd0;
            bc      <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
            rx_data <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs      <= 1'b1;
            sck     <= 1'b1;
            mosi    <= 1'b1;
        end else begin
            state   <= state_n;
            ph      <= ph_n;
            bc      <= bc_n;
            tx_sr   <= tx_n;
            rx_sr   <= rx_n;
            rx_data <= rx_data_n;
            busy    <= busy_n;
            done    <= done_n;
            cs      <= cs_n;
            sck     <= sck_n;
            mosi    <= mosi_n;
        end
    end
endmodule
